// File: rtl/clk_divide_multi_if.sv
// Config/enable/output bundle for the multi-channel clock divider.
// master: the controlling block; slave: the divider itself.
interface clk_divide_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    en;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [CNT_WIDTH-1:0] cfg_high;
  logic                 cfg_err;
  logic [NUM_CH-1:0]    clk_out;
  logic [NUM_CH-1:0]    tick;

  modport master (
    output en, cfg_valid, cfg_ch, cfg_period, cfg_high,
    input  cfg_ready, cfg_err, clk_out, tick
  );

  modport slave (
    input  en, cfg_valid, cfg_ch, cfg_period, cfg_high,
    output cfg_ready, cfg_err, clk_out, tick
  );
endinterface

// File: rtl/clk_divide_multi.sv
// NUM_CH independent clock dividers with runtime-programmable period and
// high time. New settings land in a per-channel shadow register and are
// applied only at a period boundary (or immediately while the channel is
// disabled), keeping clk_out/tick glitch-free.
// Optional macro CLK_DIV_SYNC_EN adds a 'sync' input that restarts every
// enabled channel at count 0 on the same edge.
module clk_divide_multi #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int DEFAULT_PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic sync,
`endif
  clk_divide_multi_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD  = 1 << CH_W;
  localparam logic [CH_W:0]          CH_LIM = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_WIDTH-1:0]   ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   TWO    = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]   DEF_P  = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0]   DEF_H  = DEF_P >> 1;

  // active settings and counter per channel
  logic [CNT_WIDTH-1:0] per_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] high_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] per_n  [NUM_CH];
  logic [CNT_WIDTH-1:0] high_n [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_n  [NUM_CH];

  // shadow settings waiting for the next period boundary
  logic [CNT_WIDTH-1:0] sh_per  [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_high [NUM_CH];

  logic [NUM_CH-1:0] pend_q, pend_n;
  logic [NUM_CH-1:0] clk_q, clk_n;
  logic [NUM_CH-1:0] tick_q, tick_n;
  logic              err_q, err_n;

  logic [PAD-1:0]    pend_pad;
  logic              ready;
  logic              xfer;
  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_sel;
  logic              sync_now;

`ifdef CLK_DIV_SYNC_EN
  assign sync_now = sync;
`else
  assign sync_now = 1'b0;
`endif

  // Out-of-range channel indices read a zero pending bit, so such writes
  // are always consumed (and then flagged as errors).
  assign pend_pad = PAD'(pend_q);
  assign ready    = ~pend_pad[bus.cfg_ch];

  assign bus.cfg_ready = ready;
  assign bus.clk_out   = clk_q;
  assign bus.tick      = tick_q;
  assign bus.cfg_err   = err_q;

  // decode a config transfer into a per-channel shadow write strobe
  always_comb begin
    wr_sel = '0;
    xfer   = bus.cfg_valid & ready;
    cfg_ok = ({1'b0, bus.cfg_ch} < CH_LIM) && (bus.cfg_period >= TWO);
    err_n  = xfer & ~cfg_ok;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel[c] = xfer && cfg_ok && (bus.cfg_ch == CH_W'(c));
    end
  end

  // per-channel next state: idle, sync restart, wrap/apply, or count
  always_comb begin
    logic [CNT_WIDTH-1:0] p_use;
    logic [CNT_WIDTH-1:0] h_use;
    logic                 wrap;
    for (int c = 0; c < NUM_CH; c++) begin
      p_use     = pend_q[c] ? sh_per[c]  : per_q[c];
      h_use     = pend_q[c] ? sh_high[c] : high_q[c];
      wrap      = (cnt_q[c] == per_q[c] - ONE);
      per_n[c]  = per_q[c];
      high_n[c] = high_q[c];
      cnt_n[c]  = cnt_q[c];
      pend_n[c] = pend_q[c];
      clk_n[c]  = 1'b0;
      tick_n[c] = 1'b0;
      if (!bus.en[c]) begin
        // idle: park at the last count so the first enabled edge wraps to 0
        per_n[c]  = p_use;
        high_n[c] = h_use;
        cnt_n[c]  = p_use - ONE;
        pend_n[c] = 1'b0;
      end else if (sync_now || wrap) begin
        per_n[c]  = p_use;
        high_n[c] = h_use;
        cnt_n[c]  = '0;
        clk_n[c]  = (h_use != '0);
        tick_n[c] = !sync_now && (p_use == ONE);
        pend_n[c] = 1'b0;
      end else begin
        cnt_n[c]  = cnt_q[c] + ONE;
        clk_n[c]  = (cnt_n[c] < high_q[c]);
        tick_n[c] = (cnt_n[c] == per_q[c] - ONE);
      end
      // a write on this edge is only queued; it never hits this boundary
      if (wr_sel[c]) begin
        pend_n[c] = 1'b1;
      end
    end
  end

  // shadow capture; only consumed while pending is set, so no reset needed
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_sel[c]) begin
        sh_per[c]  <= bus.cfg_period;
        sh_high[c] <= bus.cfg_high;
      end
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        per_q[c]  <= DEF_P;
        high_q[c] <= DEF_H;
        cnt_q[c]  <= DEF_P - ONE;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      err_q  <= 1'b0;
    end else begin
      per_q  <= per_n;
      high_q <= high_n;
      cnt_q  <= cnt_n;
      pend_q <= pend_n;
      clk_q  <= clk_n;
      tick_q <= tick_n;
      err_q  <= err_n;
    end
  end
endmodule

// File: tb/tb_clk_divide_multi.sv
// Self-checking bench for clk_divide_multi: directed steps from the test
// plan followed by a randomized run, all checked every cycle against a
// phase-based reference model. Honours CLK_DIV_SYNC_EN when defined.
module tb_clk_divide_multi;
  localparam int NUM_CH    = 4;
  localparam int CNT_WIDTH = 16;
  localparam int DEF_P     = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   sync_drv = 1'b0;

  always #5 clk = ~clk;

  clk_divide_multi_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  clk_divide_multi #(
    .NUM_CH(NUM_CH),
    .CNT_WIDTH(CNT_WIDTH),
    .DEFAULT_PERIOD(DEF_P)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CLK_DIV_SYNC_EN
    .sync(sync_drv),
`endif
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // reference model: phase -1 means idle, otherwise position in the period
  int m_per[NUM_CH], m_high[NUM_CH], m_phase[NUM_CH];
  int m_sp[NUM_CH], m_sh[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_per[c] = DEF_P; m_high[c] = DEF_P / 2; m_phase[c] = -1; m_pend[c] = 0;
    end
    m_err = 0;
  endtask

  task automatic take(input int c);
    if (m_pend[c]) begin
      m_per[c] = m_sp[c]; m_high[c] = m_sh[c]; m_pend[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [NUM_CH-1:0] en, input bit acc, input int ch,
                            input int p, input int h, input bit sy);
    for (int c = 0; c < NUM_CH; c++) begin
      if (!en[c]) begin
        take(c); m_phase[c] = -1;
      end else if (sy || m_phase[c] < 0 || m_phase[c] == m_per[c] - 1) begin
        take(c); m_phase[c] = 0;
      end else begin
        m_phase[c]++;
      end
    end
    m_err = acc && (p < 2);
    if (acc && p >= 2) begin
      m_sp[ch] = p; m_sh[ch] = h; m_pend[ch] = 1;
    end
  endtask

  task automatic set_cfg(input bit v, input int ch, input int p, input int h);
    bus.cfg_valid  = v;
    bus.cfg_ch     = 2'(ch);
    bus.cfg_period = CNT_WIDTH'(p);
    bus.cfg_high   = CNT_WIDTH'(h);
  endtask

  // one clock: check ready before the edge, advance model, check outputs after
  task automatic cycle();
    int ch;
    bit rdy_exp, acc;
    logic [NUM_CH-1:0] exp_clk, exp_tick;
    @(negedge clk);
    ch      = int'(bus.cfg_ch);
    rdy_exp = !m_pend[ch];
    check("cfg_ready", bus.cfg_ready, rdy_exp);
    acc = bus.cfg_valid && rdy_exp;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(bus.en, acc, ch, int'(bus.cfg_period), int'(bus.cfg_high), sync_drv);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_clk[c]  = (m_phase[c] >= 0) && (m_phase[c] < m_high[c]);
      exp_tick[c] = (m_phase[c] >= 0) && (m_phase[c] == m_per[c] - 1);
    end
    check("clk_out", bus.clk_out, exp_clk);
    check("tick", bus.tick, exp_tick);
    check("cfg_err", bus.cfg_err, m_err);
  endtask

  initial begin
    int hi, tk, p;
    bus.en = '0;
    set_cfg(0, 0, 0, 0);

    // reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_clk_out", bus.clk_out, 0);
    check("rst_tick", bus.tick, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);

    // release with ch0 enabled: 5 high, 5 low, tick on 10th cycle
    rst = 1'b1;
    bus.en = 4'b0001;
    hi = 0; tk = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      hi += int'(bus.clk_out[0]);
      tk += int'(bus.tick[0]);
    end
    check("ch0_high_cycles", hi, 5);
    check("ch0_ticks", tk, 1);
    check("ch0_tick_10th", bus.tick[0], 1);
    check("other_ch_idle", bus.clk_out[3:1], 0);

    // ch1 running at P=10; write P=4,H=1 at cnt=3
    bus.en = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      if (m_phase[1] == 3) break;
      cycle();
    end
    set_cfg(1, 1, 4, 1);
    cycle();
    // second write to ch1 stalls while pending
    set_cfg(1, 1, 8, 2);
    #1;
    check("ch1_stall_ready", bus.cfg_ready, 0);
    cycle();
    // a write to another channel still goes through
    set_cfg(1, 2, 6, 0);
    #1;
    check("ch2_ready", bus.cfg_ready, 1);
    cycle();
    // hold the ch1 write until it is taken after the wrap
    set_cfg(1, 1, 8, 2);
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (m_sp[1] == 8) break;
    end
    check("ch1_second_write_taken", m_sp[1], 8);
    set_cfg(0, 0, 0, 0);

    // invalid period: consumed, error pulse, nothing changes
    set_cfg(1, 3, 1, 2);
    cycle();
    set_cfg(0, 0, 0, 0);
    check("cfg_err_pulse", bus.cfg_err, 1);
    cycle();
    check("cfg_err_clear", bus.cfg_err, 0);

    // ch2 P=6,H=0: clk_out stuck low, tick every 6 cycles
    bus.en = 4'b0111;
    hi = 0; tk = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      hi += int'(bus.clk_out[2]);
      tk += int'(bus.tick[2]);
    end
    check("h0_high_cycles", hi, 0);
    check("h0_ticks", tk, 2);

    // ch2 H=P=6: clk_out stuck high
    set_cfg(1, 2, 6, 6);
    cycle();
    set_cfg(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (!m_pend[2]) break;
      cycle();
    end
    hi = 0; tk = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      hi += int'(bus.clk_out[2]);
      tk += int'(bus.tick[2]);
    end
    check("hp_high_cycles", hi, 12);
    check("hp_ticks", tk, 2);

    // drop ch0 enable at cnt=2, then restart
    for (int i = 0; i < 20; i++) begin
      if (m_phase[0] == 2) break;
      cycle();
    end
    bus.en[0] = 1'b0;
    cycle();
    check("dis_clk_out0", bus.clk_out[0], 0);
    check("dis_tick0", bus.tick[0], 0);
    bus.en[0] = 1'b1;
    cycle();
    check("reen_clk_out0", bus.clk_out[0], 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.en = NUM_CH'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        p = int'($urandom_range(0, 9));
        set_cfg(1, int'($urandom_range(0, 3)), p, int'($urandom_range(0, p + 1)));
      end else begin
        set_cfg(0, 0, 0, 0);
      end
      cycle();
    end

    // reset mid-period with a write pending
    bus.en = '1;
    set_cfg(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (!m_pend[0]) break;
      cycle();
    end
    set_cfg(1, 0, 3, 1);
    cycle();
    set_cfg(0, 0, 0, 0);
    rst = 1'b0;
    cycle();
    check("midrst_clk_out", bus.clk_out, 0);
    check("midrst_tick", bus.tick, 0);
    check("midrst_ready", bus.cfg_ready, 1);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cycle();

`ifdef CLK_DIV_SYNC_EN
    // phase-align ch0 (P=4) and ch1 (P=6)
    bus.en = 4'b0011;
    set_cfg(1, 0, 4, 2);
    cycle();
    set_cfg(1, 1, 6, 3);
    cycle();
    set_cfg(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (!m_pend[0] && !m_pend[1]) break;
      cycle();
    end
    repeat (3) cycle();
    sync_drv = 1'b1;
    cycle();
    sync_drv = 1'b0;
    check("sync_ch0_high", bus.clk_out[0], 1);
    check("sync_ch1_high", bus.clk_out[1], 1);
    for (int i = 0; i < 12; i++) cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
